// File: rtl/renee_wheel_driver.sv
// Purpose: turns one-hot Renee wheel actions into soft-start PWM H-bridge drive with reversal dead-time.
// Latency: an accepted command shows on the outputs one cycle later; the duty ramps once per PWM period.
// Backpressure: cmd_ready drops while either wheel is in dead-time; otherwise a command is taken every cycle.
// Option: define RENEE_WHEEL_ODO_EN to build the signed per-wheel odometry counters (l_odo/r_odo read 0 otherwise).
module renee_wheel_driver #(
  parameter int PWM_W       = 8,
  parameter int DUTY_MAX    = 200,
  parameter int RAMP_STEP   = 8,
  parameter int DEAD_CYCLES = 16,
  parameter int ODO_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       lwa,
  input  logic [2:0]       rwa,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  output logic             cmd_err,
  output logic             l_pwm,
  output logic             r_pwm,
  output logic             l_dir,
  output logic             r_dir,
  output logic             l_brake,
  output logic             r_brake,
  output logic [ODO_W-1:0] l_odo,
  output logic [ODO_W-1:0] r_odo
);

  localparam int SUM_W = PWM_W + 2;
  localparam int DC_W  = $clog2(DEAD_CYCLES + 1);

  localparam logic [SUM_W-1:0] STEP_V   = SUM_W'(RAMP_STEP);
  localparam logic [SUM_W-1:0] MAX_V    = SUM_W'(DUTY_MAX);
  localparam logic [DC_W-1:0]  DEAD_V   = DC_W'(DEAD_CYCLES);
  localparam logic [DC_W-1:0]  DEAD_ONE = DC_W'(1);
  localparam logic [PWM_W-1:0] PWM_ONE  = PWM_W'(1);

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_DEAD = 2'd2
  } state_t;

  // Index 0 is the left wheel, index 1 the right wheel.
  logic [PWM_W-1:0] pwm_cnt;
  logic             wrap;
  logic             accept;
  logic             err_q;
  logic [1:0]       bad;
  logic [2:0]       code     [2];
  state_t           st_q     [2];
  state_t           st_d     [2];
  logic [1:0]       dir_q;
  logic [1:0]       dir_d;
  logic [1:0]       pend_q;
  logic [1:0]       pend_d;
  logic [PWM_W:0]   duty_q   [2];
  logic [PWM_W:0]   duty_d   [2];
  logic [DC_W-1:0]  dead_q   [2];
  logic [DC_W-1:0]  dead_d   [2];
  logic [SUM_W-1:0] ramp_sum [2];
  logic [PWM_W:0]   ramp_val [2];

  function automatic logic is_onehot(input logic [2:0] c);
    return (c == 3'b100) || (c == 3'b010) || (c == 3'b001);
  endfunction

  assign code[0]   = lwa;
  assign code[1]   = rwa;
  assign wrap      = &pwm_cnt;
  assign cmd_ready = (st_q[0] != ST_DEAD) && (st_q[1] != ST_DEAD);
  assign accept    = cmd_valid & cmd_ready;
  assign bad       = {~is_onehot(rwa), ~is_onehot(lwa)};

  // Saturating ramp target, computed one bit wider so duty+step cannot wrap.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      ramp_sum[w] = {1'b0, duty_q[w]} + STEP_V;
      ramp_val[w] = (ramp_sum[w] > MAX_V) ? MAX_V[PWM_W:0] : ramp_sum[w][PWM_W:0];
    end
  end

  // Per-wheel next state: command decode, ramp, dead-time countdown.
  // A command taken on a wrap cycle replaces that wheel's ramp step, except a
  // same-direction repeat, which simply leaves the ramp running.
  always_comb begin
    for (int w = 0; w < 2; w++) begin
      st_d[w]   = st_q[w];
      dir_d[w]  = dir_q[w];
      pend_d[w] = pend_q[w];
      duty_d[w] = duty_q[w];
      dead_d[w] = dead_q[w];
      case (st_q[w])
        ST_STOP: begin
          if (accept && !bad[w] && !code[w][0]) begin
            st_d[w]   = ST_RUN;
            dir_d[w]  = code[w][2];
            duty_d[w] = '0;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (bad[w] || code[w][0]) begin
              st_d[w]   = ST_STOP;
              duty_d[w] = '0;
            end else if (code[w][2] == dir_q[w]) begin
              if (wrap) duty_d[w] = ramp_val[w];
            end else begin
              // Reversal: bridge off, old dir held, new dir parked until dead-time ends.
              st_d[w]   = ST_DEAD;
              dead_d[w] = DEAD_V;
              pend_d[w] = code[w][2];
              duty_d[w] = '0;
            end
          end else if (wrap) begin
            duty_d[w] = ramp_val[w];
          end
        end
        ST_DEAD: begin
          dead_d[w] = dead_q[w] - DEAD_ONE;
          if (dead_q[w] <= DEAD_ONE) begin
            st_d[w]   = ST_RUN;
            dir_d[w]  = pend_q[w];
            duty_d[w] = '0;
            dead_d[w] = '0;
          end
        end
        default: begin
          st_d[w]   = ST_STOP;
          duty_d[w] = '0;
          dead_d[w] = '0;
        end
      endcase
    end
  end

  // State registers, shared PWM counter and the one-cycle decode-error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pwm_cnt <= '0;
      err_q   <= 1'b0;
      dir_q   <= 2'b11;
      pend_q  <= 2'b11;
      for (int w = 0; w < 2; w++) begin
        st_q[w]   <= ST_STOP;
        duty_q[w] <= '0;
        dead_q[w] <= '0;
      end
    end else begin
      pwm_cnt <= pwm_cnt + PWM_ONE;
      err_q   <= accept & (|bad);
      dir_q   <= dir_d;
      pend_q  <= pend_d;
      for (int w = 0; w < 2; w++) begin
        st_q[w]   <= st_d[w];
        duty_q[w] <= duty_d[w];
        dead_q[w] <= dead_d[w];
      end
    end
  end

  assign cmd_err = err_q;
  assign l_pwm   = (st_q[0] == ST_RUN) && ({1'b0, pwm_cnt} < duty_q[0]);
  assign r_pwm   = (st_q[1] == ST_RUN) && ({1'b0, pwm_cnt} < duty_q[1]);
  assign l_dir   = dir_q[0];
  assign r_dir   = dir_q[1];
  assign l_brake = (st_q[0] == ST_STOP);
  assign r_brake = (st_q[1] == ST_STOP);

`ifdef RENEE_WHEEL_ODO_EN
  localparam logic [ODO_W-1:0] ODO_ONE = ODO_W'(1);
  logic [ODO_W-1:0] odo_q [2];

  // Signed period count: one step per wrap while actually driving, sign from dir.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      odo_q[0] <= '0;
      odo_q[1] <= '0;
    end else begin
      for (int w = 0; w < 2; w++) begin
        if (wrap && (st_q[w] == ST_RUN) && (duty_q[w] != '0)) begin
          odo_q[w] <= dir_q[w] ? (odo_q[w] + ODO_ONE) : (odo_q[w] - ODO_ONE);
        end
      end
    end
  end

  assign l_odo = odo_q[0];
  assign r_odo = odo_q[1];
`else
  assign l_odo = '0;
  assign r_odo = '0;
`endif

endmodule
